// File: rtl/mcu_cpu_port_pkg.sv
// Shared definitions for the CPU memory port: state encoding, read timing and bus widths.
package mcu_cpu_port_pkg;

  localparam int unsigned AddrW        = 26;
  localparam int unsigned DataW        = 32;
  localparam int unsigned PhaseW       = 3;

  // Backend read latency used when the instantiator does not override it (legal 1..3).
  localparam int unsigned RdLatDefault = 2;

  // Cycle offsets, counted from the accept cycle, at which each read word is presented.
  localparam int unsigned RdOff0       = 4;
  localparam int unsigned RdOff1       = 5;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRlead,
    StRd0,
    StRd1,
    StRearm
  } state_e;

  // Second word of a read pair: same address with bit 0 inverted.
  function automatic logic [AddrW-1:0] pair_addr(input logic [AddrW-1:0] a);
    return {a[AddrW-1:1], ~a[0]};
  endfunction

endpackage

// File: rtl/mcu_cpu_port.sv
// CPU-side memory port: grants the bus when idle and not held by DMA, accepts one request,
// issues a single write or a two-word read pair to the backend, then rearms once the
// initiator has dropped its request.
module mcu_cpu_port
  import mcu_cpu_port_pkg::*;
#(
  parameter int unsigned RD_LAT = RdLatDefault
) (
  input  logic             MCU_CLK,
  input  logic             RST,
  input  logic             dma_hold,
  output logic             dma_mcu_access,
  input  logic             mem_do_act,
  input  logic [AddrW-1:0] mem_addr,
  input  logic             mem_we,
  input  logic [DataW-1:0] mem_dataintomem,
  output logic             mem_ack,
  output logic [DataW-1:0] mem_datafrommem,
  output logic [AddrW-1:0] ram_addr,
  output logic             ram_re,
  output logic             ram_we,
  output logic [DataW-1:0] ram_wdata,
  input  logic [DataW-1:0] ram_rdata
);

  // Phase values (cycles since accept) at which strobes fire and read data is captured.
  localparam logic [PhaseW-1:0] LeadLast = PhaseW'(RdOff0 - 1);
  localparam logic [PhaseW-1:0] ReP0     = PhaseW'(RdOff0 - RD_LAT);
  localparam logic [PhaseW-1:0] ReP1     = PhaseW'(RdOff1 - RD_LAT);

  state_e            state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [AddrW-1:0]  addr_q, addr_d, base_addr;
  logic              grant_q, grant_d;
  logic              ack_q, ack_d;
  logic              re_q, re_d;
  logic              we_q, we_d;
  logic [AddrW-1:0]  raddr_q, raddr_d;
  logic [DataW-1:0]  wdata_q, wdata_d;
  logic [DataW-1:0]  rdout_q, rdout_d;
  logic              accept, rd_next, hit0, hit1, capture;

  // Next-state: accept in IDLE, sequence write or read pair, rearm on a low request.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (grant_q && mem_do_act) begin
          accept  = 1'b1;
          state_d = mem_we ? StWrite : StRlead;
          phase_d = PhaseW'(1);
        end
      end
      StWrite: begin
        state_d = StRearm;
        phase_d = '0;
      end
      StRlead: begin
        phase_d = phase_q + PhaseW'(1);
        if (phase_q == LeadLast) state_d = StRd0;
      end
      StRd0: begin
        phase_d = phase_q + PhaseW'(1);
        state_d = StRd1;
      end
      StRd1: begin
        phase_d = '0;
        state_d = StRearm;
      end
      StRearm: begin
        // A request still held from the last transaction must drop before re-granting.
        if (!mem_do_act) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        phase_d = '0;
      end
    endcase
  end

  // Next values of the registered outputs and the request latch.
  always_comb begin
    // At the accept edge the latch is not loaded yet, so take the address from the bus.
    base_addr = accept ? mem_addr : addr_q;
    addr_d    = base_addr;
    rd_next   = (state_d inside {StRlead, StRd0, StRd1});
    hit0      = rd_next && (phase_d == ReP0);
    hit1      = rd_next && (phase_d == ReP1);
    re_d      = hit0 | hit1;
    we_d      = accept & mem_we;
    raddr_d   = raddr_q;
    if (we_d || hit0) begin
      raddr_d = base_addr;
    end else if (hit1) begin
      raddr_d = pair_addr(base_addr);
    end
    wdata_d   = we_d ? mem_dataintomem : wdata_q;
    // Capture each word on the edge before the cycle in which it must be shown.
    capture   = ((state_q == StRlead) && (phase_q == LeadLast)) || (state_q == StRd0);
    rdout_d   = capture ? ram_rdata : rdout_q;
    // Grant follows the next state so it drops on the same edge that accepts.
    grant_d   = (state_d == StIdle) && !dma_hold;
    ack_d     = accept;
  end

  // State and output registers, all cleared by the asynchronous reset.
  always_ff @(posedge MCU_CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      phase_q <= '0;
      addr_q  <= '0;
      grant_q <= 1'b0;
      ack_q   <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      raddr_q <= '0;
      wdata_q <= '0;
      rdout_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      re_q    <= re_d;
      we_q    <= we_d;
      raddr_q <= raddr_d;
      wdata_q <= wdata_d;
      rdout_q <= rdout_d;
    end
  end

  assign dma_mcu_access  = grant_q;
  assign mem_ack         = ack_q;
  assign mem_datafrommem = rdout_q;
  assign ram_addr        = raddr_q;
  assign ram_re          = re_q;
  assign ram_we          = we_q;
  assign ram_wdata       = wdata_q;

endmodule
